pwm_cfg_sequencer: RTL and testbench

//  Wishbone B4 classic master that programs one pwm_timer channel from a single command.

---
 rtl/pwm_cfg_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
// Wishbone B4 classic master that programs one pwm_timer channel per command:
// write PERIODn, write DCn, write CTRL, then read CTRL back and compare under a mask.
module pwm_cfg_sequencer #(
    parameter logic [15:0] BASE     = 16'h0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  CMP_MASK = 8'h5F
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_ch,
    input  logic [15:0] i_cmd_period,
    input  logic [15:0] i_cmd_dc,
    input  logic [7:0]  i_cmd_ctrl,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [15:0] i_wb_data,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_PER, S_G1, S_DC, S_G2, S_CTL, S_G3, S_RB, S_FIN
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] dc_q, dc_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic [15:0] per_adr_new;
    logic [15:0] dc_adr;
    logic        rb_match;
    logic        unused_rd_hi;

    // Channel stride is 4 bytes; the sums wrap naturally at 16 bits.
    assign per_adr_new  = BASE + 16'd4 + {12'd0, i_cmd_ch, 2'b00};
    assign dc_adr       = BASE + 16'd6 + {12'd0, ch_q, 2'b00};
    assign rb_match     = ((i_wb_data[7:0] & CMP_MASK) == (ctrl_q & CMP_MASK));
    assign unused_rd_hi = ^i_wb_data[15:8];

    // ready_q low while in IDLE marks the single done/err pulse cycle,
    // after which ready/busy settle to their idle values.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dc_d    = dc_q;
        ctrl_d  = ctrl_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (!ready_q) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (i_cmd_valid) begin
                    ch_d    = i_cmd_ch;
                    dc_d    = i_cmd_dc;
                    ctrl_d  = i_cmd_ctrl;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = per_adr_new;
                    data_d  = i_cmd_period;
                    cnt_d   = 16'd0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    code_d  = 2'd0;
                    state_d = S_PER;
                end
            end
            S_PER, S_DC, S_CTL, S_RB: begin
                // Ack wins over a timeout that expires on the same edge.
                if (i_wb_ack) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    case (state_q)
                        S_PER:   state_d = S_G1;
                        S_DC:    state_d = S_G2;
                        S_CTL:   state_d = S_G3;
                        default: begin
                            if (rb_match) begin
                                state_d = S_FIN;
                            end else begin
                                state_d = S_IDLE;
                                err_d   = 1'b1;
                                code_d  = 2'd2;
                            end
                        end
                    endcase
                end else if (cnt_q + 16'd1 == TO_LIMIT) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_G1: begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = dc_adr;
                data_d  = dc_q;
                cnt_d   = 16'd0;
                state_d = S_DC;
            end
            S_G2: begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = BASE;
                data_d  = {8'h00, ctrl_q};
                cnt_d   = 16'd0;
                state_d = S_CTL;
            end
            S_G3: begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                adr_d   = BASE;
                cnt_d   = 16'd0;
                state_d = S_RB;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ch_q    <= 2'd0;
            dc_q    <= 16'd0;
            ctrl_q  <= 8'd0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 16'd0;
            data_q  <= 16'd0;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dc_q    <= dc_d;
            ctrl_q  <= ctrl_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_err_code  = code_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_data   = data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: table of single commands against a Wishbone slave
// model, then timeout, reset-in-CTL and back-to-back sequences.
module tb_pwm_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_ch = 2'd0;
    logic [15:0] i_cmd_period = 16'd0;
    logic [15:0] i_cmd_dc = 16'd0;
    logic [7:0]  i_cmd_ctrl = 8'd0;
    logic        o_busy, o_done, o_err;
    logic [1:0]  o_err_code;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [15:0] o_wb_adr, o_wb_data;
    logic        i_wb_ack;
    logic [15:0] i_wb_data;
    logic [3:0]  o_dbg_state;

    pwm_cfg_sequencer #(.BASE(16'h0000), .TIMEOUT(16), .CMP_MASK(8'h5F)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ch(i_cmd_ch), .i_cmd_period(i_cmd_period),
        .i_cmd_dc(i_cmd_dc), .i_cmd_ctrl(i_cmd_ctrl),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Slave model: registered ack (one wait state) or level-held ack,
    // optional stall on one address, CTRL register echo or forced readback.
    logic        level_mode = 1'b0;
    logic        nack_en = 1'b0;
    logic [15:0] nack_adr = 16'h0000;
    logic        rb_ovr = 1'b0;
    logic [15:0] rb_val = 16'h0000;
    logic        ack_r;
    logic [7:0]  ctrl_reg;
    int          ack_cnt;
    logic [32:0] cap_q[$];
    logic [32:0] exp_q[$];

    assign i_wb_ack  = ack_r;
    assign i_wb_data = rb_ovr ? rb_val : {8'h00, ctrl_reg};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r    <= 1'b0;
            ctrl_reg <= 8'h00;
            ack_cnt  <= 0;
        end else begin
            if (o_wb_cyc && o_wb_stb && ack_r) begin
                cap_q.push_back({o_wb_we, o_wb_adr, o_wb_we ? o_wb_data : 16'h0000});
                ack_cnt <= ack_cnt + 1;
                if (o_wb_we && o_wb_adr == 16'h0000) ctrl_reg <= o_wb_data[7:0];
            end
            if (o_wb_cyc && o_wb_stb && !(nack_en && o_wb_adr == nack_adr))
                ack_r <= level_mode ? 1'b1 : !ack_r;
            else
                ack_r <= 1'b0;
        end
    end

    // Bus monitor sampled on the falling edge.
    int checks = 0;
    int errors = 0;
    int stb_viol = 0;
    int gap_viol = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stb_len = 0;
    int last_len = 0;
    int ack_seen = 0;

    always @(negedge clk) begin
        if (o_wb_stb !== o_wb_cyc) stb_viol++;
        if (ack_cnt != ack_seen) begin
            if (o_wb_cyc) gap_viol++;
            ack_seen = ack_cnt;
        end
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (o_wb_cyc) stb_len++;
        else if (stb_len > 0) begin
            last_len = stb_len;
            stb_len = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_caps(input string name);
        chk({name, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("%s_xfer%0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    task automatic push_cmd_exp(input logic [15:0] per_adr, input logic [15:0] dc_adr,
                                input logic [15:0] per, input logic [15:0] dc,
                                input logic [7:0] ctrl);
        exp_q.push_back({1'b1, per_adr, per});
        exp_q.push_back({1'b1, dc_adr, dc});
        exp_q.push_back({1'b1, 16'h0000, {8'h00, ctrl}});
        exp_q.push_back({1'b0, 16'h0000, 16'h0000});
    endtask

    task automatic run_cmd(input logic [1:0] ch, input logic [15:0] per, input logic [15:0] dc,
                           input logic [7:0] ctrl, output int lat, output logic got_done,
                           output logic got_err, output logic [1:0] code);
        int w;
        w = 0;
        @(negedge clk);
        while (!o_cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", 64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_ch = ch;
        i_cmd_period = per;
        i_cmd_dc = dc;
        i_cmd_ctrl = ctrl;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_ch = 2'($urandom_range(0, 3));
        i_cmd_period = 16'($urandom);
        i_cmd_dc = 16'($urandom);
        i_cmd_ctrl = 8'($urandom);
        lat = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        code = 2'd0;
        while (lat < 300 && !got_done && !got_err) begin
            @(posedge clk);
            #1;
            lat++;
            got_done = o_done;
            got_err = o_err;
            code = o_err_code;
        end
    endtask

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] per;
        logic [15:0] dc;
        logic [7:0]  ctrl;
        logic        ovr;
        logic [15:0] rbv;
        logic [15:0] per_adr;
        logic [15:0] dc_adr;
        logic        exp_done;
        logic [1:0]  exp_code;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        logic got_done, got_err;
        logic [1:0] code;
        int d0, e0, cyc_n;
        logic seen;

        vecs[0] = '{2'd0, 16'h0008, 16'h0006, 8'h16, 1'b0, 16'h0000, 16'h0004, 16'h0006, 1'b1, 2'd0, 12};
        vecs[1] = '{2'd3, 16'hFFFF, 16'h0000, 8'h1F, 1'b0, 16'h0000, 16'h0010, 16'h0012, 1'b1, 2'd0, 12};
        vecs[2] = '{2'd1, 16'h1234, 16'h0567, 8'h16, 1'b1, 16'h00B6, 16'h0008, 16'h000A, 1'b1, 2'd0, 12};
        vecs[3] = '{2'd2, 16'h00AA, 16'h0055, 8'h16, 1'b1, 16'h0017, 16'h000C, 16'h000E, 1'b0, 2'd2, 11};
        vecs[4] = '{2'd2, 16'h0100, 16'h0080, 8'hA5, 1'b0, 16'h0000, 16'h000C, 16'h000E, 1'b1, 2'd0, 12};
        vecs[5] = '{2'd1, 16'h7FFF, 16'h0001, 8'h16, 1'b1, 16'hFF16, 16'h0008, 16'h000A, 1'b1, 2'd0, 12};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({o_cmd_ready, o_busy, o_done, o_err, o_err_code, o_wb_cyc, o_wb_stb, o_wb_we,
                 o_wb_adr, o_wb_data}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single commands, registered-ack slave
        for (int v = 0; v < 6; v++) begin
            cap_q.delete();
            exp_q.delete();
            rb_ovr = vecs[v].ovr;
            rb_val = vecs[v].rbv;
            push_cmd_exp(vecs[v].per_adr, vecs[v].dc_adr, vecs[v].per, vecs[v].dc, vecs[v].ctrl);
            run_cmd(vecs[v].ch, vecs[v].per, vecs[v].dc, vecs[v].ctrl, lat, got_done, got_err, code);
            chk($sformatf("v%0d_done", v), 64'(got_done), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_err", v), 64'(got_err), 64'(!vecs[v].exp_done));
            chk($sformatf("v%0d_code", v), 64'(code), 64'(vecs[v].exp_code));
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_pulse_cycle_busy_ready", v), 64'({o_busy, o_cmd_ready}), 64'(2'b10));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_after_pulse", v),
                64'({o_busy, o_cmd_ready, o_done, o_err, o_err_code}),
                64'({1'b0, 1'b1, 1'b0, 1'b0, vecs[v].exp_code}));
            chk_caps($sformatf("v%0d", v));
        end
        rb_ovr = 1'b0;

        // Timeout: DC write never acked
        cap_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b1, 16'h0004, 16'h0021});
        nack_en = 1'b1;
        nack_adr = 16'h0006;
        run_cmd(2'd0, 16'h0021, 16'h0011, 8'h16, lat, got_done, got_err, code);
        chk("to_err", 64'({got_done, got_err}), 64'(2'b01));
        chk("to_code", 64'(code), 64'd1);
        chk("to_latency", 64'(lat), 64'd19);
        repeat (2) @(negedge clk);
        chk("to_stb_cycles", 64'(last_len), 64'd16);
        chk("to_ready_again", 64'({o_cmd_ready, o_busy, o_wb_cyc}), 64'(3'b100));
        chk_caps("to");
        nack_en = 1'b0;

        // Reset while the CTRL write is on the bus
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_ch = 2'd1;
        i_cmd_period = 16'h0040;
        i_cmd_dc = 16'h0020;
        i_cmd_ctrl = 8'h16;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        cyc_n = 0;
        @(negedge clk);
        while (!(o_wb_cyc && o_wb_we && o_wb_adr == 16'h0000) && cyc_n < 100) begin
            @(negedge clk);
            cyc_n++;
        end
        chk("rst_reached_ctl", 64'(cyc_n < 100), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_bus", 64'({o_wb_cyc, o_wb_stb}), 64'(2'b00));
        chk("rst_ready", 64'({o_cmd_ready, o_busy}), 64'(2'b10));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_pulses", 64'({32'(done_cnt - d0), 32'(err_cnt - e0)}), 64'd0);
        chk("rst_idle_after", 64'({o_cmd_ready, o_busy, o_wb_cyc}), 64'(3'b100));

        // Back-to-back with valid held high and a level-held ack
        level_mode = 1'b1;
        cap_q.delete();
        exp_q.delete();
        push_cmd_exp(16'h0008, 16'h000A, 16'h0300, 16'h0100, 8'h16);
        push_cmd_exp(16'h0010, 16'h0012, 16'h0500, 16'h0280, 8'h1F);
        d0 = done_cnt;
        e0 = err_cnt;
        gap_viol = 0;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_ch = 2'd1;
        i_cmd_period = 16'h0300;
        i_cmd_dc = 16'h0100;
        i_cmd_ctrl = 8'h16;
        @(posedge clk);
        #1;
        chk("b2b_first_accept", 64'(o_busy), 64'd1);
        i_cmd_ch = 2'd3;
        i_cmd_period = 16'h0500;
        i_cmd_dc = 16'h0280;
        i_cmd_ctrl = 8'h1F;
        cyc_n = 0;
        seen = 1'b0;
        while (!o_done && cyc_n < 300) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        chk("b2b_first_done", 64'(o_done), 64'd1);
        chk("b2b_not_ready_in_done", 64'(o_cmd_ready), 64'd0);
        while (o_busy && cyc_n < 300) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        chk("b2b_ready_gap", 64'(o_cmd_ready), 64'd1);
        while (!o_busy && cyc_n < 300) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        i_cmd_valid = 1'b0;
        while (!o_done && !o_err && cyc_n < 300) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
        chk("b2b_second_done", 64'(o_done), 64'd1);
        repeat (10) @(negedge clk);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        chk("b2b_err_count", 64'(err_cnt - e0), 64'd0);
        chk("b2b_gap_violations", 64'(gap_viol), 64'd0);
        chk_caps("b2b");
        level_mode = 1'b0;

        chk("stb_equals_cyc", 64'(stb_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
